// File: rtl/ifsel_arbiter.sv
// Two-source arbiter feeding a single-entry output register. Picks a source by
// fixed priority or round-robin, then holds the word until the consumer takes it.
module ifsel_arbiter #(
  parameter int WIDTH       = 32,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             src0_valid,
  input  logic [WIDTH-1:0] src0_data,
  output logic             src0_ready,
  input  logic             src1_valid,
  input  logic [WIDTH-1:0] src1_data,
  output logic             src1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [15:0]      xfer_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic             last_src_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_src_reg;
  logic [15:0]      xfer_count_reg;

  logic             grant;
  logic             accept;
  logic             any_valid;
  logic             take;
  logic             drain;

  assign any_valid = src0_valid | src1_valid;

  // With no source valid the grant is irrelevant (nothing is taken); it just
  // mirrors last_src so both modes share one well-defined decode.
  generate
    if (ROUND_ROBIN) begin : g_round_robin
      always_comb begin
        grant = last_src_reg;
        if (src0_valid && src1_valid) begin
          grant = ~last_src_reg;
        end else if (src0_valid) begin
          grant = 1'b0;
        end else if (src1_valid) begin
          grant = 1'b1;
        end
      end
    end else begin : g_fixed_priority
      always_comb begin
        grant = last_src_reg;
        if (src0_valid) begin
          grant = 1'b0;
        end else if (src1_valid) begin
          grant = 1'b1;
        end
      end
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (any_valid) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_next = any_valid ? FULL : EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Output decode; handshakes are held low while reset is asserted.
  always_comb begin
    out_valid  = (state_reg == FULL);
    accept     = rst_n && ((state_reg == EMPTY) || out_ready);
    take       = accept && any_valid;
    drain      = (state_reg == FULL) && out_ready;
    src0_ready = accept && !grant && src0_valid;
    src1_ready = accept &&  grant && src1_valid;
  end

  // Datapath: the held word, its source, arbitration history and transfer count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg   <= '0;
      out_src_reg    <= 1'b0;
      last_src_reg   <= 1'b1;
      xfer_count_reg <= 16'd0;
    end else begin
      if (take) begin
        out_data_reg <= grant ? src1_data : src0_data;
        out_src_reg  <= grant;
        last_src_reg <= grant;
      end
      if (drain) begin
        xfer_count_reg <= xfer_count_reg + 16'd1;
      end
    end
  end

  assign out_data   = out_data_reg;
  assign out_src    = out_src_reg;
  assign xfer_count = xfer_count_reg;

endmodule

// File: tb/tb_ifsel_arbiter.sv
// Directed bench for ifsel_arbiter: a round-robin instance and a fixed-priority
// instance share stimulus; expected values are hand-computed constants.
module tb_ifsel_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         src0_valid;
  logic [W-1:0] src0_data;
  logic         src1_valid;
  logic [W-1:0] src1_data;
  logic         out_ready;

  logic         rr_src0_ready, rr_src1_ready, rr_out_valid, rr_out_src;
  logic [W-1:0] rr_out_data;
  logic [15:0]  rr_xfer_count;
  logic         fp_src0_ready, fp_src1_ready, fp_out_valid, fp_out_src;
  logic [W-1:0] fp_out_data;
  logic [15:0]  fp_xfer_count;

  int passed;
  int failed;
  int total;

  ifsel_arbiter #(.WIDTH(W), .ROUND_ROBIN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src0_valid (src0_valid),
    .src0_data  (src0_data),
    .src0_ready (rr_src0_ready),
    .src1_valid (src1_valid),
    .src1_data  (src1_data),
    .src1_ready (rr_src1_ready),
    .out_valid  (rr_out_valid),
    .out_data   (rr_out_data),
    .out_src    (rr_out_src),
    .out_ready  (out_ready),
    .xfer_count (rr_xfer_count)
  );

  ifsel_arbiter #(.WIDTH(W), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk        (clk),
    .rst_n      (rst_n),
    .src0_valid (src0_valid),
    .src0_data  (src0_data),
    .src0_ready (fp_src0_ready),
    .src1_valid (src1_valid),
    .src1_data  (src1_data),
    .src1_ready (fp_src1_ready),
    .out_valid  (fp_out_valid),
    .out_data   (fp_out_data),
    .out_src    (fp_out_src),
    .out_ready  (out_ready),
    .xfer_count (fp_xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    rst_n = 1'b0;
    src0_valid = 1'b1; src0_data = 32'h0; // valid during reset must not be acknowledged
    src1_valid = 1'b0; src1_data = 32'h0;
    out_ready  = 1'b0;

    #2;
    check("rst_out_valid", {31'd0, rr_out_valid}, 32'd0);
    check("rst_out_data", rr_out_data, 32'd0);
    check("rst_out_src", {31'd0, rr_out_src}, 32'd0);
    check("rst_xfer", {16'd0, rr_xfer_count}, 32'd0);
    check("rst_src0_ready", {31'd0, rr_src0_ready}, 32'd0);
    src0_valid = 1'b0;
    #10 rst_n = 1'b1;  // t=12, between edges

    // Single word from source 0, consumer stalled
    src0_valid = 1'b1; src0_data = 32'h3;
    #1;
    check("load_src0_ready", {31'd0, rr_src0_ready}, 32'd1);
    check("load_src1_ready", {31'd0, rr_src1_ready}, 32'd0);
    tick();
    check("load_out_valid", {31'd0, rr_out_valid}, 32'd1);
    check("load_out_data", rr_out_data, 32'h3);
    check("load_out_src", {31'd0, rr_out_src}, 32'd0);
    check("hold_src0_ready", {31'd0, rr_src0_ready}, 32'd0);
    src0_data = 32'h7;  // not accepted while stalled
    tick();
    check("hold_out_data", rr_out_data, 32'h3);
    check("hold_out_valid", {31'd0, rr_out_valid}, 32'd1);
    check("hold_xfer", {16'd0, rr_xfer_count}, 32'd0);

    // Drain with sources idle
    src0_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("drain_out_valid", {31'd0, rr_out_valid}, 32'd0);
    check("drain_out_data", rr_out_data, 32'h3);
    check("drain_xfer", {16'd0, rr_xfer_count}, 32'd1);
    tick();
    check("empty_ready_ignored", {16'd0, rr_xfer_count}, 32'd1);

    // Fill from source 1 and stall, then reset asynchronously mid-cycle
    out_ready = 1'b0; src1_valid = 1'b1; src1_data = 32'h5;
    tick();
    check("fill1_out_src", {31'd0, rr_out_src}, 32'd1);
    check("fill1_out_data", rr_out_data, 32'h5);
    src1_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, rr_out_valid}, 32'd0);
    check("async_rst_out_data", rr_out_data, 32'd0);
    check("async_rst_xfer", {16'd0, rr_xfer_count}, 32'd0);
    #2 rst_n = 1'b1;

    // Both sources valid, consumer always ready
    src0_valid = 1'b1; src0_data = 32'hA;
    src1_valid = 1'b1; src1_data = 32'hB;
    out_ready  = 1'b1;
    #1;
    check("tie_rr_src0_ready", {31'd0, rr_src0_ready}, 32'd1);
    check("tie_rr_src1_ready", {31'd0, rr_src1_ready}, 32'd0);
    tick();
    check("rr_seq0_data", rr_out_data, 32'hA);
    check("rr_seq0_src", {31'd0, rr_out_src}, 32'd0);
    check("rr_seq0_xfer", {16'd0, rr_xfer_count}, 32'd0);
    check("fp_seq0_data", fp_out_data, 32'hA);
    check("rr_seq1_ready1", {31'd0, rr_src1_ready}, 32'd1);
    check("fp_seq1_ready1", {31'd0, fp_src1_ready}, 32'd0);
    tick();
    check("rr_seq1_data", rr_out_data, 32'hB);
    check("rr_seq1_src", {31'd0, rr_out_src}, 32'd1);
    check("rr_seq1_xfer", {16'd0, rr_xfer_count}, 32'd1);
    check("fp_seq1_data", fp_out_data, 32'hA);
    check("fp_seq1_ready1", {31'd0, fp_src1_ready}, 32'd0);
    tick();
    check("rr_seq2_data", rr_out_data, 32'hA);
    check("rr_seq2_xfer", {16'd0, rr_xfer_count}, 32'd2);
    check("fp_seq2_data", fp_out_data, 32'hA);
    tick();
    check("rr_seq3_data", rr_out_data, 32'hB);
    check("rr_seq3_valid", {31'd0, rr_out_valid}, 32'd1);
    check("rr_seq3_xfer", {16'd0, rr_xfer_count}, 32'd3);
    check("fp_seq3_data", fp_out_data, 32'hA);
    check("fp_seq3_xfer", {16'd0, fp_xfer_count}, 32'd3);

    src0_valid = 1'b0; src1_valid = 1'b0;
    tick();
    check("rr_drain2_valid", {31'd0, rr_out_valid}, 32'd0);
    check("rr_drain2_data", rr_out_data, 32'hB);
    check("rr_drain2_xfer", {16'd0, rr_xfer_count}, 32'd4);
    check("fp_drain2_data", fp_out_data, 32'hA);

    // Counter wrap: reset, stream source 0; after k edges the count is k-1
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    src0_valid = 1'b1; src0_data = 32'h1;
    for (int i = 0; i < 65536; i++) begin
      tick();
    end
    check("wrap_pre_xfer", {16'd0, rr_xfer_count}, 32'hFFFF);
    tick();
    check("wrap_xfer", {16'd0, rr_xfer_count}, 32'd0);
    check("wrap_fp_xfer", {16'd0, fp_xfer_count}, 32'd0);
    out_ready = 1'b0;
    #1;
    check("stall_src0_ready", {31'd0, rr_src0_ready}, 32'd0);
    tick();
    check("stall_xfer", {16'd0, rr_xfer_count}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
